video_out_fetch: RTL and testbench

Reads a complete frame from RAM as a Wishbone master and pushes it, one 32-bit word at a time, into the video-out pixel FIFO that feeds the display path. It is the read-side counterpart of the video-in store block. It sits between the shared Wishbone bus and the video_out FIFO. The processor supplies each frame's base address, and the block raises an interrupt when the frame has been fully fetched.

---
 rtl/video_out_fetch_pkg.sv | 21 ++
 rtl/video_out_fetch_if.sv | 24 ++
 rtl/video_out_fetch.sv | 210 +++++++++++++++++++++
 tb/tb_video_out_fetch.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_out_fetch_pkg.sv
// Shared types and helpers for the video-out frame fetcher.
package video_out_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ROOM = 2'd1,
        BURST     = 2'd2,
        RETRY     = 2'd3
    } state_t;

    // Each 32-bit FIFO word carries four 8-bit pixels, pixel 0 in the low byte
    localparam int unsigned PIX_PER_WORD = 4;

    // Number of 32-bit words making up one frame
    function automatic int unsigned frame_words(input int unsigned width,
                                                input int unsigned height);
        return (width * height) / PIX_PER_WORD;
    endfunction

endpackage

// File: rtl/video_out_fetch_if.sv
// Wishbone read-master bus between the frame fetcher and the shared bus.
interface video_out_fetch_if;
    logic        p_wb_CYC_O;
    logic        p_wb_STB_O;
    logic        p_wb_LOCK_O;
    logic        p_wb_WE_O;
    logic [3:0]  p_wb_SEL_O;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_I;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;

    modport master (
        output p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O,
               p_wb_SEL_O, p_wb_ADR_O,
        input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I
    );

    modport slave (
        input  p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O,
               p_wb_SEL_O, p_wb_ADR_O,
        output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I
    );
endinterface

// File: rtl/video_out_fetch.sv
// Fetches a whole frame from RAM in fixed-length Wishbone read bursts and
// pushes each word into the video-out pixel FIFO; raises interrupt when done.
module video_out_fetch
    import video_out_pkg::*;
#(
    parameter int unsigned P_WIDTH  = 640,
    parameter int unsigned P_HEIGHT = 480,
    parameter int unsigned NB_PACK  = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [31:0]       base_addr,
    input  logic              base_valid,
    input  logic              fifo_room,
    output logic [31:0]       fifo_data,
    output logic              fifo_we,
    output logic              interrupt,
    video_out_fetch_if.master wb
);

    localparam int unsigned FRAME_WORDS = frame_words(P_WIDTH, P_HEIGHT);
    localparam int unsigned WIDX_W      = 17;
    localparam int unsigned BCNT_W      = $clog2(NB_PACK) + 1;

    // Reject geometries that cannot be fetched in whole bursts
    if (NB_PACK == 0 || FRAME_WORDS == 0 || (FRAME_WORDS % NB_PACK) != 0) begin : g_bad_burst
        $error("video_out_fetch: frame words must be a non-zero multiple of NB_PACK");
    end
    if (FRAME_WORDS >= (1 << WIDX_W)) begin : g_bad_frame
        $error("video_out_fetch: frame too large for the word index");
    end

    state_t              state_q, state_d;

    logic [31:0]         pend_base_q;
    logic                pend_q;
    logic [31:0]         frame_base_q;
    logic [31:0]         adr_q;
    logic [WIDX_W-1:0]   widx_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic                cyc_q;
    logic [31:0]         fifo_data_q;
    logic                fifo_we_q;
    logic                irq_q;

    logic                burst_last_c;
    logic                frame_last_c;

    logic                load_frame_c;
    logic                start_burst_c;
    logic                take_word_c;
    logic                end_burst_c;
    logic                err_abort_c;
    logic                resume_c;
    logic                frame_done_c;

    assign burst_last_c = (bcnt_q == BCNT_W'(NB_PACK - 1));
    assign frame_last_c = (widx_q == WIDX_W'(FRAME_WORDS - 1));

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: ERR_I wins over a simultaneous ACK_I
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = WAIT_ROOM;
                end
            end
            WAIT_ROOM: begin
                if (fifo_room) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (wb.p_wb_ERR_I) begin
                    state_d = RETRY;
                end else if (wb.p_wb_ACK_I && burst_last_c) begin
                    state_d = frame_last_c ? IDLE : WAIT_ROOM;
                end
            end
            RETRY: begin
                state_d = BURST;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-state datapath controls
    always_comb begin
        load_frame_c  = 1'b0;
        start_burst_c = 1'b0;
        take_word_c   = 1'b0;
        end_burst_c   = 1'b0;
        err_abort_c   = 1'b0;
        resume_c      = 1'b0;
        frame_done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                load_frame_c = pend_q;
            end
            WAIT_ROOM: begin
                start_burst_c = fifo_room;
            end
            BURST: begin
                if (wb.p_wb_ERR_I) begin
                    err_abort_c = 1'b1;
                end else if (wb.p_wb_ACK_I) begin
                    take_word_c = 1'b1;
                    if (burst_last_c) begin
                        end_burst_c  = 1'b1;
                        frame_done_c = frame_last_c;
                    end
                end
            end
            RETRY: begin
                resume_c = 1'b1;
            end
            default: begin
                load_frame_c = 1'b0;
            end
        endcase
    end

    // Pending base: latest processor write wins, consumed when a frame starts
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pend_base_q <= '0;
            pend_q      <= 1'b0;
        end else if (base_valid) begin
            pend_base_q <= base_addr;
            pend_q      <= 1'b1;
        end else if (load_frame_c) begin
            pend_q <= 1'b0;
        end
    end

    // Frame/burst counters, bus address and cycle control
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            frame_base_q <= '0;
            adr_q        <= '0;
            widx_q       <= '0;
            bcnt_q       <= '0;
            cyc_q        <= 1'b0;
        end else begin
            if (load_frame_c) begin
                frame_base_q <= pend_base_q;
                widx_q       <= '0;
            end
            if (start_burst_c) begin
                bcnt_q <= '0;
                adr_q  <= frame_base_q + 32'({widx_q, 2'b00});
                cyc_q  <= 1'b1;
            end
            if (take_word_c) begin
                widx_q <= widx_q + WIDX_W'(1);
                adr_q  <= adr_q + 32'd4;
                bcnt_q <= bcnt_q + BCNT_W'(1);
            end
            if (end_burst_c || err_abort_c) begin
                cyc_q <= 1'b0;
            end
            if (resume_c) begin
                cyc_q <= 1'b1;
            end
        end
    end

    // FIFO write port and frame-done interrupt
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            fifo_data_q <= '0;
            fifo_we_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            fifo_we_q <= take_word_c;
            if (take_word_c) begin
                fifo_data_q <= wb.p_wb_DAT_I;
            end
            if (load_frame_c) begin
                irq_q <= 1'b0;
            end else if (frame_done_c) begin
                irq_q <= 1'b1;
            end
        end
    end

    assign fifo_data      = fifo_data_q;
    assign fifo_we        = fifo_we_q;
    assign interrupt      = irq_q;

    assign wb.p_wb_CYC_O  = cyc_q;
    assign wb.p_wb_STB_O  = cyc_q;
    assign wb.p_wb_LOCK_O = cyc_q;
    assign wb.p_wb_WE_O   = 1'b0;
    assign wb.p_wb_SEL_O  = 4'hF;
    assign wb.p_wb_ADR_O  = adr_q;

endmodule

// File: tb/tb_video_out_fetch.sv
// Directed bench for video_out_fetch: 16x2 frame (8 words), bursts of 4.
module tb_video_out_fetch;

    localparam int unsigned P_W = 16;
    localparam int unsigned P_H = 2;
    localparam int unsigned NB  = 4;
    localparam int unsigned FW  = P_W * P_H / 4;

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] base_addr;
    logic        base_valid;
    logic        fifo_room;
    logic [31:0] fifo_data;
    logic        fifo_we;
    logic        interrupt;

    always #5 clk = ~clk;

    video_out_fetch_if wb();

    logic s_ack = 1'b0;
    logic s_err = 1'b0;
    assign wb.p_wb_ACK_I = s_ack;
    assign wb.p_wb_ERR_I = s_err;
    assign wb.p_wb_DAT_I = wb.p_wb_ADR_O;

    video_out_fetch #(.P_WIDTH(P_W), .P_HEIGHT(P_H), .NB_PACK(NB)) dut (
        .clk        (clk),
        .RST        (RST),
        .base_addr  (base_addr),
        .base_valid (base_valid),
        .fifo_room  (fifo_room),
        .fifo_data  (fifo_data),
        .fifo_we    (fifo_we),
        .interrupt  (interrupt),
        .wb         (wb)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
    endtask

    // Slave: wait_states idle cycles before each ACK, one-shot ERR at err_adr
    int          wait_states = 0;
    logic        err_armed   = 1'b0;
    logic [31:0] err_adr     = '0;
    int          s_cnt       = 0;
    logic        s_prev      = 1'b0;

    always @(negedge clk) begin
        #1;
        if (!(wb.p_wb_CYC_O && wb.p_wb_STB_O)) begin
            s_cnt  = 0;
            s_ack  = 1'b0;
            s_err  = 1'b0;
            s_prev = 1'b0;
        end else begin
            if (!s_prev || s_ack || s_err) s_cnt = 0;
            else                           s_cnt = s_cnt + 1;
            if (err_armed && wb.p_wb_ADR_O == err_adr) begin
                s_err     = 1'b1;
                s_ack     = 1'b0;
                err_armed = 1'b0;
            end else begin
                s_err = 1'b0;
                s_ack = (s_cnt == wait_states);
            end
            s_prev = 1'b1;
        end
    end

    // Reference model: a frame is the word sequence base, base+4, ... in order
    logic [31:0] exp_q[$];

    task automatic expect_frame(input logic [31:0] base);
        for (int i = 0; i < int'(FW); i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Observed per-test statistics
    logic [31:0] rise_adr[$];
    int          gaps[$];
    int          burst_we[$];
    int          irq_runs[$];
    int          gap = 0, we_seg = 0, we_test = 0, we_at_irq = -1, irq_len = 0;
    bit          seen_rise = 0, irq_counting = 0, got_first = 0;
    logic [31:0] first_data = '0, last_data = '0, prev_adr = '0;
    logic        prev_cyc = 1'b0, prev_irq = 1'b0;

    // Compare process: outputs checked every cycle out of reset
    always @(negedge clk) begin
        if (RST) begin
            prev_cyc = 1'b0;
            prev_irq = 1'b0;
            gap      = 0;
        end else begin
            if (wb.p_wb_CYC_O) begin
                chk("stb_with_cyc", 32'(wb.p_wb_STB_O), 32'd1);
                chk("lock_with_cyc", 32'(wb.p_wb_LOCK_O), 32'd1);
                chk("we_o", 32'(wb.p_wb_WE_O), 32'd0);
                chk("sel_o", 32'(wb.p_wb_SEL_O), 32'hF);
                if (!prev_cyc) begin
                    rise_adr.push_back(wb.p_wb_ADR_O);
                    if (seen_rise) begin
                        gaps.push_back(gap);
                        burst_we.push_back(we_seg);
                    end
                    seen_rise = 1;
                    we_seg    = 0;
                end else if (s_ack) begin
                    chk("adr_step", wb.p_wb_ADR_O, prev_adr + 32'd4);
                end else begin
                    chk("adr_hold", wb.p_wb_ADR_O, prev_adr);
                end
                gap = 0;
            end else begin
                chk("stb_idle", 32'(wb.p_wb_STB_O), 32'd0);
                chk("lock_idle", 32'(wb.p_wb_LOCK_O), 32'd0);
                gap = gap + 1;
            end
            if (fifo_we) begin
                we_test++;
                we_seg++;
                if (!got_first) begin
                    first_data = fifo_data;
                    got_first  = 1;
                end
                last_data = fifo_data;
                if (exp_q.size() == 0) chk("unexpected_we", 32'(fifo_we), 32'd0);
                else                   chk("fifo_data", fifo_data, exp_q.pop_front());
            end
            if (interrupt && !prev_irq) begin
                irq_len      = 1;
                irq_counting = 1;
                if (we_at_irq < 0) we_at_irq = we_test;
            end else if (interrupt) begin
                irq_len++;
            end else if (prev_irq && irq_counting) begin
                irq_runs.push_back(irq_len);
                irq_counting = 0;
            end
            prev_cyc = wb.p_wb_CYC_O;
            prev_adr = wb.p_wb_ADR_O;
            prev_irq = interrupt;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_stats();
        rise_adr.delete();
        gaps.delete();
        burst_we.delete();
        irq_runs.delete();
        we_seg = 0; we_test = 0; we_at_irq = -1; irq_len = 0;
        seen_rise = 0; irq_counting = 0; got_first = 0;
    endtask

    task automatic pulse_base(input logic [31:0] b);
        base_addr  = b;
        base_valid = 1'b1;
        step();
        base_valid = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && interrupt) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail_timeout(name);
        repeat (4) step();
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_we(input int cnt, input int budget, input string name);
        int n = 0;
        while (we_test < cnt && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail_timeout(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        RST        = 1'b1;
        base_addr  = '0;
        base_valid = 1'b0;
        fifo_room  = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_fifo_data", fifo_data, 32'd0);
        chk("rst_fifo_we", 32'(fifo_we), 32'd0);
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_cyc", 32'(wb.p_wb_CYC_O), 32'd0);
        chk("rst_stb", 32'(wb.p_wb_STB_O), 32'd0);
        chk("rst_lock", 32'(wb.p_wb_LOCK_O), 32'd0);
        chk("rst_adr", wb.p_wb_ADR_O, 32'd0);
        chk("rst_we_o", 32'(wb.p_wb_WE_O), 32'd0);
        chk("rst_sel", 32'(wb.p_wb_SEL_O), 32'hF);
        RST = 1'b0;
        step();

        // Plain frame at 0x1000, zero-wait slave
        clear_stats();
        expect_frame(32'h1000);
        pulse_base(32'h1000);
        wait_frame(200, "t1_frame");
        chk("t1_words", 32'(we_test), 32'd8);
        chk("t1_first", first_data, 32'h0000_1000);
        chk("t1_last", last_data, 32'h0000_101C);
        chk("t1_bursts", 32'(rise_adr.size()), 32'd2);
        chk("t1_rise0", rise_adr[0], 32'h1000);
        chk("t1_rise1", rise_adr[1], 32'h1010);
        chk("t1_gap", 32'(gaps[0]), 32'd1);
        chk("t1_burst_we", 32'(burst_we[0]), 32'd4);
        chk("t1_irq_at_word", 32'(we_at_irq), 32'd8);
        chk("t1_irq", 32'(interrupt), 32'd1);

        // No room for 10 cycles between bursts; drop during BURST is ignored
        clear_stats();
        expect_frame(32'h1000);
        pulse_base(32'h1000);
        wait_we(2, 100, "t2_start");
        fifo_room = 1'b0;
        begin
            int n = 0;
            while (wb.p_wb_CYC_O && n < 50) begin
                step();
                n++;
            end
            if (n >= 50) fail_timeout("t2_burst_end");
        end
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_cyc_low", 32'(wb.p_wb_CYC_O), 32'd0);
            chk("t2_no_we", 32'(fifo_we), 32'd0);
        end
        fifo_room = 1'b1;
        wait_frame(200, "t2_frame");
        chk("t2_words", 32'(we_test), 32'd8);
        chk("t2_first_burst", 32'(burst_we[0]), 32'd4);
        chk("t2_rise1", rise_adr[1], 32'h1010);
        chk("t2_gap", 32'(gaps[0]), 32'd11);

        // ERR on the third word of the first burst
        clear_stats();
        err_adr   = 32'h1008;
        err_armed = 1'b1;
        expect_frame(32'h1000);
        pulse_base(32'h1000);
        wait_frame(200, "t3_frame");
        chk("t3_words", 32'(we_test), 32'd8);
        chk("t3_rises", 32'(rise_adr.size()), 32'd3);
        chk("t3_retry_adr", rise_adr[1], 32'h1008);
        chk("t3_retry_gap", 32'(gaps[0]), 32'd1);
        chk("t3_burst0_we", 32'(burst_we[0] + burst_we[1]), 32'd4);
        chk("t3_rise2", rise_adr[2], 32'h1010);

        // New base mid-frame: current frame finishes, next starts at 0x2000
        clear_stats();
        expect_frame(32'h1000);
        expect_frame(32'h2000);
        pulse_base(32'h1000);
        wait_we(1, 100, "t4_start");
        pulse_base(32'h2000);
        wait_frame(300, "t4_frames");
        chk("t4_words", 32'(we_test), 32'd16);
        chk("t4_rises", 32'(rise_adr.size()), 32'd4);
        chk("t4_rise2", rise_adr[2], 32'h2000);
        chk("t4_irq_at_word", 32'(we_at_irq), 32'd8);
        chk("t4_irq_pulse", 32'(irq_runs[0]), 32'd1);
        chk("t4_irq_end", 32'(interrupt), 32'd1);

        // Reset mid-burst with a base pending: everything abandoned
        clear_stats();
        expect_frame(32'h3000);
        pulse_base(32'h3000);
        wait_we(1, 100, "t5_start");
        pulse_base(32'h4000);
        wait_we(2, 100, "t5_mid");
        RST = 1'b1;
        #1;
        chk("t5_cyc_async", 32'(wb.p_wb_CYC_O), 32'd0);
        chk("t5_stb_async", 32'(wb.p_wb_STB_O), 32'd0);
        chk("t5_we_async", 32'(fifo_we), 32'd0);
        exp_q.delete();
        step();
        step();
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t5_idle_cyc", 32'(wb.p_wb_CYC_O), 32'd0);
        end
        chk("t5_irq", 32'(interrupt), 32'd0);
        chk("t5_words", 32'(we_test), 32'd2);

        // Slave with two wait states per word
        clear_stats();
        wait_states = 2;
        expect_frame(32'h1000);
        pulse_base(32'h1000);
        wait_frame(400, "t6_frame");
        chk("t6_words", 32'(we_test), 32'd8);
        chk("t6_rises", 32'(rise_adr.size()), 32'd2);
        chk("t6_burst_we", 32'(burst_we[0]), 32'd4);
        chk("t6_rise1", rise_adr[1], 32'h1010);
        chk("t6_last", last_data, 32'h101C);
        wait_states = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
